// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t     : loader FSM states
//   IMEM_BYTES  : instruction memory depth in bytes (max image length)
//   IMEM_ADDR_W : byte address width of the memory write port
//   CSUM_INIT   : starting value of the running XOR checksum
package imem_pkg;

  localparam int          IMEM_BYTES  = 36;
  localparam int          IMEM_ADDR_W = 6;
  localparam logic [7:0]  CSUM_INIT   = 8'h00;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    CHK_LEN,
    PAYLOAD,
    CSUM,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_frame_ctr.sv
// Frame length register and payload index counter.
//   clk, reset   : clock, synchronous active-low reset
//   cap_lo/hi    : load len[7:0] / len[15:8] from in_data
//   clr_idx      : zero the payload index
//   inc          : advance the payload index
//   in_data      : stream byte
//   addr         : current payload byte address
//   last         : current index is the final payload byte (idx == len-1)
//   len_bad      : captured length is too large or not a multiple of 4
//   len_zero     : captured length is zero
module imem_frame_ctr
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int ADDR_W    = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_lo,
  input  logic              cap_hi,
  input  logic              clr_idx,
  input  logic              inc,
  input  logic [7:0]        in_data,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              len_bad,
  output logic              len_zero
);

  logic [15:0]     len;
  // One spare bit so idx+1 at the final byte cannot wrap into a false match.
  logic [ADDR_W:0] idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      len <= '0;
      idx <= '0;
    end else begin
      if (cap_lo) len[7:0]  <= in_data;
      if (cap_hi) len[15:8] <= in_data;
      if (clr_idx)  idx <= '0;
      else if (inc) idx <= idx + 1'b1;
    end
  end

  assign addr     = idx[ADDR_W-1:0];
  // Full 16-bit compares; len==0 never reaches PAYLOAD so len-1 underflow is harmless.
  assign last     = ({{(16-ADDR_W-1){1'b0}}, idx} == (len - 16'd1));
  assign len_bad  = (len > 16'(MEM_BYTES)) || (len[1:0] != 2'b00);
  assign len_zero = (len == 16'd0);

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: takes a framed byte stream (LEN_LO, LEN_HI, payload, CSUM),
// writes the payload to instruction memory from address 0 and releases the
// core from reset once the XOR checksum matches.
//   clk, reset          : clock, synchronous active-low reset
//   restart             : reload request, honoured in DONE/ERROR only
//   in_data/valid/ready : byte stream handshake
//   mem_we/addr/wdata   : registered byte write port
//   core_rst_n          : core reset, released after a verified load
//   busy, done          : loader status
//   err_len, err_csum   : sticky error flags until restart
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int ADDR_W    = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              err_csum
);

  state_t            state, nxt;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr;
  logic              last, len_bad, len_zero;
  logic              acc, pay_acc, csum_acc, csum_ok, do_restart;

  assign busy       = (state == HDR_LO) || (state == HDR_HI) ||
                      (state == PAYLOAD) || (state == CSUM);
  assign in_ready   = reset && busy;
  assign acc        = in_valid && in_ready;
  assign pay_acc    = acc && (state == PAYLOAD);
  assign csum_acc   = acc && (state == CSUM);
  assign csum_ok    = (in_data == csum);
  assign do_restart = restart && ((state == DONE) || (state == ERROR));

  imem_frame_ctr #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .cap_lo   (acc && (state == HDR_LO)),
    .cap_hi   (acc && (state == HDR_HI)),
    .clr_idx  (state == CHK_LEN),
    .inc      (pay_acc),
    .in_data  (in_data),
    .addr     (addr),
    .last     (last),
    .len_bad  (len_bad),
    .len_zero (len_zero)
  );

  always_comb begin
    nxt = state;
    case (state)
      HDR_LO:  if (acc) nxt = HDR_HI;
      HDR_HI:  if (acc) nxt = CHK_LEN;
      CHK_LEN: nxt = len_bad ? ERROR : (len_zero ? CSUM : PAYLOAD);
      PAYLOAD: if (acc && last) nxt = CSUM;
      CSUM:    if (acc) nxt = csum_ok ? DONE : ERROR;
      DONE,
      ERROR:   if (restart) nxt = HDR_LO;
      default: nxt = HDR_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= HDR_LO;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      csum       <= CSUM_INIT;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      err_len    <= 1'b0;
      err_csum   <= 1'b0;
    end else begin
      state  <= nxt;
      mem_we <= pay_acc;
      if (pay_acc) begin
        mem_addr  <= addr;
        mem_wdata <= in_data;
        csum      <= csum ^ in_data;
      end
      // Cleared even for zero-length frames so a stale sum never leaks in.
      if (state == CHK_LEN) begin
        csum <= CSUM_INIT;
        if (len_bad) err_len <= 1'b1;
      end
      if (csum_acc) begin
        if (csum_ok) begin
          done       <= 1'b1;
          core_rst_n <= 1'b1;
        end else begin
          err_csum   <= 1'b1;
        end
      end
      if (do_restart) begin
        done       <= 1'b0;
        err_len    <= 1'b0;
        err_csum   <= 1'b0;
        core_rst_n <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int MEM_BYTES = 36;
  localparam int ADDR_W    = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              restart = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready, mem_we, core_rst_n, busy, done, err_len, err_csum;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .busy(busy), .done(done),
    .err_len(err_len), .err_csum(err_csum)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, nwrites = 0;
  logic [13:0] expq[$];   // expected writes {addr, data} in order
  logic [13:0] exp_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  // Every memory write must be the next one the frame model expects.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      nwrites++;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %02h, expected no write", mem_addr, mem_wdata);
      end else begin
        exp_w = expq.pop_front();
        if ({mem_addr, mem_wdata} !== exp_w) begin
          errors++;
          $display("FAIL write: addr %0d data %02h, expected addr %0d data %02h",
                   mem_addr, mem_wdata, exp_w[13:8], exp_w[7:0]);
        end
      end
      if (mem_addr > 6'(MEM_BYTES-1)) begin
        checks++; errors++;
        $display("FAIL addr_range: addr %0d, expected <= %0d", mem_addr, MEM_BYTES-1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    bit r;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: byte %02h not accepted, expected accept within 50 cycles", b);
    end
  endtask

  // Sends a frame and checks the outcome derived from the frame rules alone.
  task automatic run_frame(input logic [15:0] len, input logic [7:0] pl[$],
                           input logic [7:0] cs, input int gap, input int rst_idx);
    bit legal     = (len <= 16'(MEM_BYTES)) && (len[1:0] == 2'b00);
    bit exp_done  = legal && (cs == xor_of(pl));
    bit exp_ecsum = legal && (cs != xor_of(pl));
    int w0 = nwrites;
    chk("pre_core_rst_n", core_rst_n, 0);
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    if (legal) begin
      for (int i = 0; i < int'(len); i++) begin
        if (i == rst_idx) restart = 1'b1;
        send_byte(pl[i], gap);
        restart = 1'b0;
        expq.push_back({6'(i), pl[i]});
      end
      send_byte(cs, gap);
      chk("core_rst_n_edge", core_rst_n, exp_done);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done", done, exp_done);
    chk("err_len", err_len, !legal);
    chk("err_csum", err_csum, exp_ecsum);
    chk("core_rst_n", core_rst_n, exp_done);
    chk("busy_end", busy, 0);
    chk("in_ready_end", in_ready, 0);
    chk("write_count", nwrites - w0, legal ? int'(len) : 0);
    chk("writes_pending", expq.size(), 0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    chk("rs_done", done, 0);
    chk("rs_err_len", err_len, 0);
    chk("rs_err_csum", err_csum, 0);
    chk("rs_core_rst_n", core_rst_n, 0);
    chk("rs_busy", busy, 1);
    chk("rs_in_ready", in_ready, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_core_rst_n"}, core_rst_n, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err_len"}, err_len, 0);
    chk({tag, "_err_csum"}, err_csum, 0);
  endtask

  initial begin
    logic [7:0] nom[$]   = '{8'h02, 8'h00, 8'h20, 8'hfc, 8'h03, 8'h00, 8'h00, 8'hfc};
    logic [7:0] four[$]  = '{8'h08, 8'h00, 8'h40, 8'hfc};
    logic [7:0] empty[$];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 1);

    // Model pins
    chk("xor_nominal", xor_of(nom), 8'h21);
    chk("xor_four", xor_of(four), 8'hb4);

    // Nominal load, then with 3-cycle gaps
    run_frame(16'd8, nom, 8'h21, 0, -1);
    chk("nom_done_lit", done, 1);
    do_restart();
    run_frame(16'd8, nom, 8'h21, 3, -1);
    chk("gap_done_lit", done, 1);
    do_restart();

    // Bad checksum then corrected frame
    run_frame(16'd4, four, 8'h00, 0, -1);
    chk("bad_csum_lit", err_csum, 1);
    do_restart();
    run_frame(16'd4, four, 8'hb4, 0, -1);
    chk("fixed_done_lit", done, 1);
    do_restart();

    // Illegal lengths and empty image
    run_frame(16'h0028, empty, 8'h00, 0, -1);
    chk("len40_lit", err_len, 1);
    do_restart();
    run_frame(16'h0006, empty, 8'h00, 0, -1);
    chk("len6_lit", err_len, 1);
    do_restart();
    run_frame(16'h0000, empty, 8'h00, 0, -1);
    chk("len0_lit", done, 1);
    do_restart();

    // Reset after third payload byte of an 8-byte frame
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      send_byte(nom[i], 0);
      expq.push_back({6'(i), nom[i]});
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("midrst_pending", expq.size(), 0);
    run_frame(16'd4, four, 8'hb4, 0, -1);
    chk("midrst_reload_lit", done, 1);
    do_restart();

    // Restart during PAYLOAD is ignored
    run_frame(16'd8, nom, 8'h21, 0, 3);
    chk("busy_restart_lit", done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the byte-addressed, little-endian instruction memory that the core reads by PC.
- Accepts a framed byte stream over a valid/ready interface and writes each payload byte to the memory's byte write port at consecutive addresses from 0.
- Holds the core in reset until the image is fully loaded and the checksum passes.
- Sits between the host link (UART/debug byte stream) and the instruction memory write port.

Parameters:
- MEM_BYTES, 36, instruction memory depth in bytes; maximum accepted image length.
- ADDR_W, 6, width of mem_addr; must satisfy 2**ADDR_W >= MEM_BYTES.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  reset, synchronous, active-low.
- restart  in  1  single-cycle request to reload; honoured only in DONE or ERROR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  ADDR_W  byte address of the write.
- mem_wdata  out  8  byte to write.
- core_rst_n  out  1  active-low reset to the core; low until a successful load.
- busy  out  1  high in HDR_LO, HDR_HI, PAYLOAD, CSUM.
- done  out  1  image loaded and verified.
- err_len  out  1  header length illegal.
- err_csum  out  1  checksum mismatch.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit byte count, little-endian), then LEN payload bytes, then one CSUM byte. CSUM is the XOR of all payload bytes, starting from 0x00.
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready. in_ready is a Moore output, high only in HDR_LO, HDR_HI, PAYLOAD and CSUM, and forced 0 while reset is low. in_data is ignored when no transfer occurs. in_valid may stay high across states.
- States and transitions:
  - HDR_LO: on accept, capture len[7:0] -> HDR_HI.
  - HDR_HI: on accept, capture len[15:8] -> CHK_LEN.
  - CHK_LEN (1 cycle, in_ready=0): if len > MEM_BYTES or len[1:0] != 0 -> ERROR with err_len=1. If len == 0 -> CSUM. Otherwise clear idx and csum -> PAYLOAD.
  - PAYLOAD: on accept, register mem_wdata=in_data and mem_addr=idx, pulse mem_we for one cycle (latency 1 cycle after accept), update csum ^= in_data and idx += 1. When the accepted byte has idx == len-1 -> CSUM.
  - CSUM: on accept, if in_data == csum -> DONE, else -> ERROR with err_csum=1.
  - DONE: done=1, core_rst_n=1. restart -> HDR_LO.
  - ERROR: error flag held, core_rst_n=0. restart -> HDR_LO.
- restart behaviour:
  - On restart, done, err_len and err_csum clear and core_rst_n goes low on the same edge.
  - restart outside DONE/ERROR is ignored.
- Reset values, applied on any edge with reset==0 (including mid-load): state=HDR_LO, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, done=0, err_len=0, err_csum=0, idx=0, len=0, csum=0.
  - Memory contents are not cleared; a partial image is left in place.
- Write-port behaviour:
  - mem_we is never asserted outside PAYLOAD+1.
  - At most one write per cycle.
  - mem_addr never exceeds MEM_BYTES-1.
- Stalls: in_valid low mid-frame holds state indefinitely. There is no timeout.
- core_rst_n is registered and glitch-free. It rises exactly one edge after the CSUM byte is accepted with a match.
- Width rules:
  - idx is ADDR_W+1 bits, so the compare with len-1 never wraps.
  - The len compare is done at full 16 bits.

Decomposition:
- Shared package imem_pkg:
  - state enum (HDR_LO, HDR_HI, CHK_LEN, PAYLOAD, CSUM, DONE, ERROR)
  - IMEM_BYTES=36
  - IMEM_ADDR_W=6
  - CSUM_INIT=8'h00
- One natural sub-module: imem_frame_ctr, holding the len/idx counter and the last-byte compare.
- FSM, checksum and write-port registers stay in imem_loader.

Test Plan:
- Nominal load:
  - Stimulus: stream 08 00, payload 02 00 20 fc 03 00 00 fc, CSUM 21, in_valid always high.
  - Required response: 8 mem_we pulses at addresses 0..7 with the payload bytes in order; core_rst_n rises 1 cycle after the CSUM accept; done=1; busy=0.
- Backpressure/gaps:
  - Stimulus: same frame with in_valid low for 3 cycles between every byte.
  - Required response: identical writes and final state; no mem_we during gaps.
- Bad checksum:
  - Stimulus: frame 04 00, payload 08 00 40 fc, CSUM 00 (expected b4).
  - Required response: 4 writes occur; err_csum=1, core_rst_n stays 0, in_ready=0.
  - Then pulse restart and send the correct frame -> done=1, err_csum cleared.
- Illegal length:
  - Stimulus: header 28 00 (40 > 36), then separately header 06 00.
  - Required response: each -> err_len=1 after CHK_LEN, zero mem_we pulses.
  - Stimulus: header 00 00 with CSUM 00.
  - Required response: done=1, zero writes.
- Reset mid-load:
  - Stimulus: assert reset low after payload byte 3 of an 8-byte frame.
  - Required response: on that edge, state=HDR_LO, all outputs at reset values, no further mem_we.
  - Stimulus: then send a full 4-byte frame.
  - Required response: it loads correctly from address 0.
- Restart ignored when busy:
  - Stimulus: pulse restart during PAYLOAD.
  - Required response: no effect; the load completes normally.
